// File: rtl/ir_rx_letter_fifo.sv
// ir_rx_letter_fifo: filters decoded IR letters into a FWFT FIFO with drop count and idle end-of-message pulse
module ir_rx_letter_fifo #(
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int DROP_W         = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     code_valid_in,
  input  logic [4:0]               code_in,
  input  logic [2:0]               error_in,
  input  logic                     data_ready_in,
  output logic                     data_valid_out,
  output logic [4:0]               data_out,
  output logic                     msg_end_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [DROP_W-1:0]        dropped_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, RECEIVING} state_t;
  state_t            state_q, state_d;
  logic [4:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, msg_end_q, msg_end_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              good, pop, push, reject;
  always_comb begin
    good      = code_valid_in && code_in <= 5'd25 && error_in == 3'd0;
    pop       = !empty_q && data_ready_in;
    // a full FIFO still accepts when the head leaves on the same edge
    push      = good && (!full_q || pop);
    reject    = code_valid_in && !push;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    full_d    = count_d == CW'(DEPTH);
    empty_d   = count_d == '0;
    dropped_d = (reject && !(&dropped_q)) ? dropped_q + DROP_W'(1) : dropped_q;
    state_d   = state_q;
    idle_d    = idle_q;
    msg_end_d = 1'b0;
    if (push) begin
      state_d = RECEIVING;
      idle_d  = '0;
    end else if (state_q == RECEIVING) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        idle_d    = '0;
        msg_end_d = 1'b1;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      msg_end_q <= 1'b0;
      dropped_q <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      msg_end_q <= msg_end_d;
      dropped_q <= dropped_d;
      idle_q    <= idle_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) mem_q[wr_ptr_q] <= code_in;
  end
  assign data_valid_out = !empty_q;
  assign data_out       = empty_q ? 5'd0 : mem_q[rd_ptr_q];
  assign msg_end_out    = msg_end_q;
  assign count_out      = count_q;
  assign full_out       = full_q;
  assign empty_out      = empty_q;
  assign dropped_out    = dropped_q;
endmodule

// File: tb/tb_ir_rx_letter_fifo.sv
// tb_ir_rx_letter_fifo: directed checks of filtering, FWFT ordering, saturation, reset and idle timeout
module tb_ir_rx_letter_fifo;
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       code_valid_in = 1'b0;
  logic [4:0] code_in = '0;
  logic [2:0] error_in = '0;
  logic       data_ready_in = 1'b0;
  logic       data_valid_out, msg_end_out, full_out, empty_out;
  logic [4:0] data_out;
  logic [2:0] count_out;
  logic [7:0] dropped_out;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk_in = ~clk_in;
  ir_rx_letter_fifo #(.DEPTH(4), .TIMEOUT_CYCLES(10), .DROP_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .code_valid_in(code_valid_in), .code_in(code_in),
    .error_in(error_in), .data_ready_in(data_ready_in), .data_valid_out(data_valid_out),
    .data_out(data_out), .msg_end_out(msg_end_out), .count_out(count_out),
    .full_out(full_out), .empty_out(empty_out), .dropped_out(dropped_out)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic push(input int code, input int err);
    code_valid_in = 1'b1;
    code_in = 5'(code);
    error_in = 3'(err);
    step();
    code_valid_in = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    int q[$];
    int mdrop, pulses;
    step();
    step();
    rst_in = 1'b0;
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_msg_end", msg_end_out, 0);
    chk("rst_dropped", dropped_out, 0);
    push(7, 0);
    chk("first_valid", data_valid_out, 1);
    chk("first_data", data_out, 7);
    idle(2);
    push(4, 0);
    idle(2);
    push(11, 0);
    chk("three_count", count_out, 3);
    chk("three_head", data_out, 7);
    data_ready_in = 1'b1;
    step();
    chk("pop1_data", data_out, 4);
    step();
    chk("pop2_data", data_out, 11);
    step();
    chk("drain_empty", empty_out, 1);
    chk("drain_valid", data_valid_out, 0);
    data_ready_in = 1'b0;
    push(26, 0);
    push(31, 0);
    push(3, 2);
    chk("rej_dropped", dropped_out, 3);
    chk("rej_empty", empty_out, 1);
    for (int i = 0; i < 260; i++) push(31, 0);
    chk("rej_saturate", dropped_out, 255);
    push(1, 0);
    push(2, 0);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("midrst_count", count_out, 0);
    chk("midrst_valid", data_valid_out, 0);
    chk("midrst_dropped", dropped_out, 0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      pulses += int'(msg_end_out);
      step();
    end
    chk("midrst_no_pulse", pulses, 0);
    for (int i = 0; i < 4; i++) push(i, 0);
    chk("fill_full", full_out, 1);
    chk("fill_count", count_out, 4);
    push(9, 0);
    chk("full_drop", dropped_out, 1);
    chk("full_count", count_out, 4);
    chk("full_head", data_out, 0);
    data_ready_in = 1'b1;
    push(9, 0);
    chk("full_pp_count", count_out, 4);
    chk("full_pp_head", data_out, 1);
    chk("full_pp_dropped", dropped_out, 1);
    step();
    chk("drain_b1", data_out, 2);
    step();
    chk("drain_b2", data_out, 3);
    step();
    chk("drain_b3", data_out, 9);
    step();
    chk("drain_b_empty", empty_out, 1);
    data_ready_in = 1'b0;
    idle(15);
    push(5, 0);
    for (int e = 1; e <= 14; e++) begin
      step();
      chk($sformatf("tmo_e%0d", e), msg_end_out, int'(e == 10));
    end
    push(5, 0);
    for (int e = 1; e <= 30; e++) begin
      if (e == 6) code_valid_in = 1'b1;
      step();
      code_valid_in = 1'b0;
      chk($sformatf("tmo_rst_e%0d", e), msg_end_out, int'(e == 16));
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    mdrop = 0;
    for (int c = 0; c < 2000; c++) begin
      bit pop, acc, v;
      int code, err;
      v = ($urandom_range(0, 3) != 0);
      code = $urandom_range(0, 28);
      err = ($urandom_range(0, 7) == 0) ? 1 : 0;
      data_ready_in = ($urandom_range(0, 2) == 0);
      code_valid_in = v;
      code_in = 5'(code);
      error_in = 3'(err);
      #1;
      chk("rnd_valid", data_valid_out, int'(q.size() > 0));
      pop = q.size() > 0 && data_ready_in;
      acc = v && code <= 25 && err == 0 && (q.size() < 4 || pop);
      if (pop) chk("rnd_data", data_out, q.pop_front());
      if (acc) q.push_back(code);
      else if (v && mdrop < 255) mdrop++;
      step();
      chk("rnd_count", count_out, q.size());
    end
    code_valid_in = 1'b0;
    chk("rnd_dropped", dropped_out, mdrop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
